commit_controller: RTL and testbench
====================================

# commit_controller

Sequences in-order retirement at the head of the reorder buffer. Each cycle it retires the head entry by one of three paths: a register write to the regfile, a store handshake with data memory, or a mispredicted-branch retirement that raises a pipeline flush. It sits between the ROB head port and the regfile/data-memory write ports. It issues the ROB dequeue strobe only after the retirement side effect is complete.

## Interface
- data_width, 16, register/memory data and address width
- tag_width, 3, ROB tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- head_valid  in  1  ROB head occupied and result ready
- head_opcode  in  lc3b_opcode  opcode of head entry
- head_dest  in  lc3b_reg  destination register
- head_tag  in  tag_width  ROB tag of head entry
- head_value  in  data_width  result value, or store data for stores
- head_addr  in  data_width  final effective store address
- head_mispredict  in  1  head is a branch resolved as mispredicted
- dest_a  out  lc3b_reg  regfile write register
- value_out  out  data_width  regfile write data
- tag_out  out  tag_width  tag the regfile compares before clearing busy
- ld_regfile_value  out  1  regfile value write strobe
- ld_regfile_busy  out  1  regfile busy-clear strobe
- RE_out  out  1  ROB head dequeue strobe
- dmem_write  out  1  data-memory write request
- dmem_address  out  data_width  store address
- dmem_wdata  out  data_width  store data, byte-lane steered
- dmem_wmask  out  2  byte enables
- dmem_resp  in  1  data-memory write complete
- flush  out  1  one-cycle pipeline flush
- commit_count  out  16  retired-instruction counter

## Operation
- State enum has three states: COMMIT, STORE, FLUSH. Reset state is COMMIT.
- While rst is high, every strobe is 0. This covers ld_regfile_value, ld_regfile_busy, RE_out, dmem_write and flush. All registered outputs also clear to 0.
- dest_a, value_out and tag_out pass head_dest, head_value and head_tag through combinationally.
- COMMIT, head_valid=0: all strobes are 0 and the state holds.
- COMMIT, head_valid with a register-writing opcode (ADD, AND, NOT, SHF, LEA, LDB, LDW, LDI, JSR, TRAP):
  - ld_regfile_value = ld_regfile_busy = RE_out = 1 in the same cycle.
  - The state stays COMMIT.
- COMMIT, head_valid with a non-writing, non-store opcode (BR, JMP, RTI, unused) and head_mispredict=0: RE_out=1 only.
- COMMIT, head_valid with head_mispredict=1: RE_out=1 and the next state is FLUSH. head_mispredict takes priority over the opcode decode.
- COMMIT, head_valid with STB, STW or STI:
  - RE_out=0.
  - The address, steered data and mask are captured into registers.
  - The next state is STORE.
- Store steering:
  - STW: mask 11, data = head_value.
  - STB: data = {value[7:0], value[7:0]}; mask is 01 if addr[0]=0, else 10.
- STORE:
  - dmem_write=1 with the captured address, data and mask held stable.
  - On dmem_resp=1: RE_out=1 in that cycle, dmem_write drops next cycle, next state COMMIT.
- FLUSH: flush=1 and all other strobes are 0. The state returns to COMMIT unconditionally.
- dmem_resp outside STORE is ignored.

## Timing
- Register-write retirement takes 0 cycles (combinational) at a throughput of one per cycle.
- Store retirement:
  - Cycle 0: capture.
  - Cycles 1..N: dmem_write held.
  - Cycle N: RE_out together with dmem_resp.
  - Cycle N+1: earliest next retirement.
- Mispredict retirement:
  - Cycle 0: RE_out.
  - Cycle 1: flush.
  - Cycle 2: earliest next retirement.
- Reset asserted mid-STORE: dmem_write is 0 in the next cycle, no RE_out is issued, and the state is COMMIT.
- rst and dmem_resp in the same cycle: reset wins and no RE_out is issued.

## Configuration
- COMMIT_PERF_EN defined:
  - commit_count is a 16-bit register, reset to 0.
  - It increments once per cycle in which RE_out=1, including mispredicted branches.
  - It wraps from 0xFFFF to 0x0000.
- COMMIT_PERF_EN undefined: commit_count is tied to 0 and no counter register exists.

## Structure
- The commit_state_t enum and a writes_reg(lc3b_opcode) decode function go in lc3b_types.
- Store byte-lane steering is one combinational sub-module, commit_store_format: inputs opcode, addr[0] and value; outputs wdata and wmask.

## Test plan
- ADD to R3, value 0x1234, head_valid for 1 cycle -> same cycle: dest_a=R3, value_out=0x1234, both ld strobes=1, RE_out=1.
- STB, addr 0x3001, value 0x00AB, dmem_resp 3 cycles after capture:
  - dmem_write held 3 cycles with wdata=0xABAB and wmask=10.
  - RE_out only in the resp cycle.
- STW, addr 0x4000, value 0xBEEF, with dmem_resp pulsed while in COMMIT beforehand -> the stray pulse is ignored and the store proceeds with mask 11.
- Mispredicted BR at head, then ADD -> RE_out at cycle 0, flush=1 at cycle 1, ADD retired at cycle 2.
- rst asserted during the STORE wait -> dmem_write=0 next cycle, no RE_out, and the next ADD retires normally.
- With COMMIT_PERF_EN, commit_count preset by retiring 0x10000 entries -> wraps to 0.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: LC-3b opcode/register types, commit FSM states and retirement decode helpers
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        OP_BR   = 4'd0,
        OP_ADD  = 4'd1,
        OP_LDB  = 4'd2,
        OP_STB  = 4'd3,
        OP_JSR  = 4'd4,
        OP_AND  = 4'd5,
        OP_LDW  = 4'd6,
        OP_STW  = 4'd7,
        OP_RTI  = 4'd8,
        OP_NOT  = 4'd9,
        OP_LDI  = 4'd10,
        OP_STI  = 4'd11,
        OP_JMP  = 4'd12,
        OP_SHF  = 4'd13,
        OP_LEA  = 4'd14,
        OP_TRAP = 4'd15
    } lc3b_opcode;

    typedef enum logic [1:0] {COMMIT, STORE, FLUSH} commit_state_t;

    function automatic logic writes_reg(lc3b_opcode op);
        return op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_LDB, OP_LDW, OP_LDI, OP_JSR, OP_TRAP};
    endfunction

    function automatic logic is_store(lc3b_opcode op);
        return op inside {OP_STB, OP_STW, OP_STI};
    endfunction

endpackage

// File: rtl/commit_store_format.sv
// commit_store_format: byte-lane steering of store data and byte enables
module commit_store_format
    import lc3b_types::*;
#(
    parameter int data_width = 16
) (
    input  lc3b_opcode            opcode,
    input  logic                  addr_lsb,
    input  logic [data_width-1:0] value,
    output logic [data_width-1:0] wdata,
    output logic [1:0]            wmask
);

    always_comb begin
        wdata = (opcode == OP_STB) ? {(data_width/8){value[7:0]}} : value;
        wmask = (opcode == OP_STB) ? (addr_lsb ? 2'b10 : 2'b01) : 2'b11;
    end

endmodule

// File: rtl/commit_controller.sv
// commit_controller: in-order ROB head retirement via regfile write, store handshake or flush
// COMMIT_PERF_EN enables the 16-bit retired-instruction counter on commit_count.
module commit_controller
    import lc3b_types::*;
#(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  lc3b_opcode            head_opcode,
    input  lc3b_reg               head_dest,
    input  logic [tag_width-1:0]  head_tag,
    input  logic [data_width-1:0] head_value,
    input  logic [data_width-1:0] head_addr,
    input  logic                  head_mispredict,
    output lc3b_reg               dest_a,
    output logic [data_width-1:0] value_out,
    output logic [tag_width-1:0]  tag_out,
    output logic                  ld_regfile_value,
    output logic                  ld_regfile_busy,
    output logic                  RE_out,
    output logic                  dmem_write,
    output logic [data_width-1:0] dmem_address,
    output logic [data_width-1:0] dmem_wdata,
    output logic [1:0]            dmem_wmask,
    input  logic                  dmem_resp,
    output logic                  flush,
    output logic [15:0]           commit_count
);

    commit_state_t         state, next_state;
    logic                  capture;
    logic [data_width-1:0] fmt_wdata;
    logic [1:0]            fmt_wmask;

    assign dest_a          = head_dest;
    assign value_out       = head_value;
    assign tag_out         = head_tag;
    assign ld_regfile_busy = ld_regfile_value;

    commit_store_format #(.data_width(data_width)) u_fmt (
        .opcode   (head_opcode),
        .addr_lsb (head_addr[0]),
        .value    (head_value),
        .wdata    (fmt_wdata),
        .wmask    (fmt_wmask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COMMIT;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            dmem_wmask   <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                dmem_address <= head_addr;
                dmem_wdata   <= fmt_wdata;
                dmem_wmask   <= fmt_wmask;
            end
        end
    end

    always_comb begin
        next_state       = state;
        capture          = 1'b0;
        ld_regfile_value = 1'b0;
        RE_out           = 1'b0;
        dmem_write       = 1'b0;
        flush            = 1'b0;
        unique case (state)
            COMMIT: if (head_valid) begin
                if (head_mispredict) begin
                    RE_out     = 1'b1;
                    next_state = FLUSH;
                end else if (is_store(head_opcode)) begin
                    capture    = 1'b1;
                    next_state = STORE;
                end else begin
                    RE_out           = 1'b1;
                    ld_regfile_value = writes_reg(head_opcode);
                end
            end
            STORE: begin
                dmem_write = 1'b1;
                RE_out     = dmem_resp;
                next_state = dmem_resp ? COMMIT : STORE;
            end
            FLUSH: begin
                flush      = 1'b1;
                next_state = COMMIT;
            end
            default: next_state = COMMIT;
        endcase
        // Reset overrides every strobe, including a same-cycle dmem_resp.
        if (rst) begin
            capture          = 1'b0;
            ld_regfile_value = 1'b0;
            RE_out           = 1'b0;
            dmem_write       = 1'b0;
            flush            = 1'b0;
        end
    end

`ifdef COMMIT_PERF_EN
    logic [15:0] count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else if (RE_out) count_q <= count_q + 16'd1;
    end
    assign commit_count = count_q;
`else
    assign commit_count = '0;
`endif

endmodule

// File: tb/tb_commit_controller.sv
// tb_commit_controller: table, directed and randomized checks of commit_controller
module tb_commit_controller;
    import lc3b_types::*;

`ifdef COMMIT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid;
    lc3b_opcode  head_opcode;
    lc3b_reg     head_dest;
    logic [2:0]  head_tag;
    logic [15:0] head_value;
    logic [15:0] head_addr;
    logic        head_mispredict;
    lc3b_reg     dest_a;
    logic [15:0] value_out;
    logic [2:0]  tag_out;
    logic        ld_regfile_value;
    logic        ld_regfile_busy;
    logic        RE_out;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_wmask;
    logic        dmem_resp;
    logic        flush;
    logic [15:0] commit_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    commit_controller #(.data_width(16), .tag_width(3)) dut (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_opcode(head_opcode),
        .head_dest(head_dest), .head_tag(head_tag), .head_value(head_value),
        .head_addr(head_addr), .head_mispredict(head_mispredict), .dest_a(dest_a),
        .value_out(value_out), .tag_out(tag_out), .ld_regfile_value(ld_regfile_value),
        .ld_regfile_busy(ld_regfile_busy), .RE_out(RE_out), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp(dmem_resp), .flush(flush), .commit_count(commit_count)
    );

    task automatic chk(input string nm, input string field, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s got %h expected %h", nm, field, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic hv, input lc3b_opcode op, input lc3b_reg d,
                         input logic [2:0] t, input logic [15:0] v, input logic [15:0] a,
                         input logic mis, input logic resp);
        rst = r; head_valid = hv; head_opcode = op; head_dest = d; head_tag = t;
        head_value = v; head_addr = a; head_mispredict = mis; dmem_resp = resp;
    endtask

    // Samples at the falling edge, then advances to just after the next rising edge.
    task automatic expect_out(input string nm, input logic re, input logic ldv, input logic dw,
                              input logic fl, input logic chk_mem, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] wm,
                              input logic chk_cnt, input logic [15:0] cnt);
        @(negedge clk);
        vectors++;
        chk(nm, "RE_out", {15'd0, RE_out}, {15'd0, re});
        chk(nm, "ld_value", {15'd0, ld_regfile_value}, {15'd0, ldv});
        chk(nm, "ld_busy", {15'd0, ld_regfile_busy}, {15'd0, ldv});
        chk(nm, "dmem_write", {15'd0, dmem_write}, {15'd0, dw});
        chk(nm, "flush", {15'd0, flush}, {15'd0, fl});
        chk(nm, "dest_a", {13'd0, dest_a}, {13'd0, head_dest});
        chk(nm, "value_out", value_out, head_value);
        chk(nm, "tag_out", {13'd0, tag_out}, {13'd0, head_tag});
        if (chk_mem) begin
            chk(nm, "dmem_address", dmem_address, addr);
            chk(nm, "dmem_wdata", dmem_wdata, wd);
            chk(nm, "dmem_wmask", {14'd0, dmem_wmask}, {14'd0, wm});
        end
        if (chk_cnt) chk(nm, "commit_count", commit_count, cnt);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       hv;
        lc3b_opcode op;
        logic       re;
        logic       ld;
    } vec_t;

    vec_t tbl[15];

    logic        m_pend, m_fl;
    logic [15:0] m_addr, m_wd, m_cnt;
    logic [1:0]  m_wm;

    initial begin
        tbl[0]  = '{1'b0, OP_ADD,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, OP_ADD,  1'b1, 1'b1};
        tbl[2]  = '{1'b1, OP_AND,  1'b1, 1'b1};
        tbl[3]  = '{1'b1, OP_NOT,  1'b1, 1'b1};
        tbl[4]  = '{1'b1, OP_SHF,  1'b1, 1'b1};
        tbl[5]  = '{1'b1, OP_LEA,  1'b1, 1'b1};
        tbl[6]  = '{1'b1, OP_LDB,  1'b1, 1'b1};
        tbl[7]  = '{1'b1, OP_LDW,  1'b1, 1'b1};
        tbl[8]  = '{1'b1, OP_LDI,  1'b1, 1'b1};
        tbl[9]  = '{1'b1, OP_JSR,  1'b1, 1'b1};
        tbl[10] = '{1'b1, OP_TRAP, 1'b1, 1'b1};
        tbl[11] = '{1'b1, OP_BR,   1'b1, 1'b0};
        tbl[12] = '{1'b1, OP_JMP,  1'b1, 1'b0};
        tbl[13] = '{1'b1, OP_RTI,  1'b1, 1'b0};
        tbl[14] = '{1'b0, OP_STW,  1'b0, 1'b0};

        drive(1, 1, OP_ADD, 3'd1, 3'd1, 16'h1111, 16'h2222, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, OP_STW, 3'd1, 3'd1, 16'h1111, 16'h2223, 1, 1);
        expect_out("reset", 0, 0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 1, 16'h0);

        for (int i = 0; i < 15; i++) begin
            drive(0, tbl[i].hv, tbl[i].op, lc3b_reg'(i), 3'(i + 1), 16'(i * 16'h0111), 16'h5555, 0, 0);
            expect_out($sformatf("tbl%0d", i), tbl[i].re, tbl[i].ld, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        end

        drive(0, 1, OP_ADD, 3'd3, 3'd5, 16'h1234, 16'h0, 0, 0);
        expect_out("add_r3", 1, 1, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);

        drive(0, 1, OP_STB, 3'd0, 3'd2, 16'h00AB, 16'h3001, 0, 0);
        expect_out("stb_cap", 0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        drive(0, 1, OP_ADD, 3'd0, 3'd2, 16'h9999, 16'h7777, 0, 0);
        expect_out("stb_w1", 0, 0, 1, 0, 1, 16'h3001, 16'hABAB, 2'b10, 0, 16'h0);
        expect_out("stb_w2", 0, 0, 1, 0, 1, 16'h3001, 16'hABAB, 2'b10, 0, 16'h0);
        dmem_resp = 1;
        expect_out("stb_resp", 1, 0, 1, 0, 1, 16'h3001, 16'hABAB, 2'b10, 0, 16'h0);
        drive(0, 0, OP_ADD, 3'd0, 3'd0, 16'h0, 16'h0, 0, 0);
        expect_out("stb_done", 0, 0, 0, 0, 1, 16'h3001, 16'hABAB, 2'b10, 0, 16'h0);

        drive(0, 0, OP_STW, 3'd0, 3'd0, 16'hBEEF, 16'h4000, 0, 1);
        expect_out("stray_resp", 0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        drive(0, 1, OP_STW, 3'd0, 3'd0, 16'hBEEF, 16'h4000, 0, 1);
        expect_out("stw_cap", 0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        expect_out("stw_resp", 1, 0, 1, 0, 1, 16'h4000, 16'hBEEF, 2'b11, 0, 16'h0);

        drive(0, 1, OP_BR, 3'd0, 3'd4, 16'h0, 16'h0, 1, 0);
        expect_out("mis_re", 1, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        drive(0, 1, OP_ADD, 3'd6, 3'd5, 16'h4242, 16'h0, 0, 0);
        expect_out("mis_flush", 0, 0, 0, 1, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        expect_out("mis_add", 1, 1, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);

        drive(0, 1, OP_STW, 3'd0, 3'd1, 16'hCAFE, 16'h0102, 0, 0);
        expect_out("rst_cap", 0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        expect_out("rst_wait", 0, 0, 1, 0, 1, 16'h0102, 16'hCAFE, 2'b11, 0, 16'h0);
        drive(1, 1, OP_STW, 3'd0, 3'd1, 16'hCAFE, 16'h0102, 0, 1);
        expect_out("rst_resp", 0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
        drive(0, 1, OP_ADD, 3'd2, 3'd3, 16'h0F0F, 16'h0, 0, 0);
        expect_out("rst_add", 1, 1, 0, 0, 1, 16'h0, 16'h0, 2'b00, 1, 16'h0);

        m_pend = 0; m_fl = 0; m_addr = 0; m_wd = 0; m_wm = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, hv, mis, resp, e_re, e_ld, e_dw, e_fl;
            lc3b_opcode op;
            logic [15:0] v, a;
            r = (n == 0) || ($urandom_range(0, 63) == 0);
            hv = $urandom_range(0, 3) != 0;
            op = lc3b_opcode'($urandom_range(0, 15));
            mis = $urandom_range(0, 7) == 0;
            resp = $urandom_range(0, 2) == 0;
            v = 16'($urandom);
            a = 16'($urandom);
            drive(r, hv, op, 3'($urandom), 3'($urandom), v, a, mis, resp);
            e_re = 0; e_ld = 0; e_dw = 0; e_fl = 0;
            if (!r) begin
                if (m_fl) e_fl = 1;
                else if (m_pend) begin e_dw = 1; e_re = resp; end
                else if (hv) begin
                    e_re = mis || !(op inside {OP_STB, OP_STW, OP_STI});
                    e_ld = !mis && (op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA,
                                               OP_LDB, OP_LDW, OP_LDI, OP_JSR, OP_TRAP});
                end
            end
            expect_out($sformatf("rand%0d", n), e_re, e_ld, e_dw, e_fl, 1, m_addr, m_wd, m_wm, 1, m_cnt);
            if (r) begin
                m_pend = 0; m_fl = 0; m_addr = 0; m_wd = 0; m_wm = 0; m_cnt = 0;
            end else begin
                m_cnt = PERF ? m_cnt + 16'(e_re) : 16'h0;
                if (m_fl) m_fl = 0;
                else if (m_pend) m_pend = !resp;
                else if (hv && mis) m_fl = 1;
                else if (hv && (op inside {OP_STB, OP_STW, OP_STI})) begin
                    m_pend = 1;
                    m_addr = a;
                    m_wd = (op == OP_STB) ? {v[7:0], v[7:0]} : v;
                    m_wm = (op == OP_STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
                end
            end
        end

`ifdef COMMIT_PERF_EN
        drive(1, 0, OP_ADD, 3'd0, 3'd0, 16'h0, 16'h0, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, OP_ADD, 3'd1, 3'd1, 16'h0001, 16'h0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        expect_out("wrap_ffff", 1, 1, 0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'hFFFF);
        expect_out("wrap_zero", 1, 1, 0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h0000);
        expect_out("wrap_one", 1, 1, 0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
